// File: rtl/rv_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB with a wait-state timeout and a sticky FAULT.
// Optional feature: define RV_ILLEGAL_TRAP_EN to trap unrecognised instructions into FAULT with illegal = 1.
module rv_control_fsm #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] instr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] pc,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        fault,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        FAULT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_LUI     = 4'd0,
        C_AUIPC   = 4'd1,
        C_JAL     = 4'd2,
        C_JALR    = 4'd3,
        C_BRANCH  = 4'd4,
        C_LOAD    = 4'd5,
        C_STORE   = 4'd6,
        C_OPIMM   = 4'd7,
        C_OP      = 4'd8,
        C_ILLEGAL = 4'd9
    } cls_t;

    // The last count value still allowed before the request is declared stuck.
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    cls_t        cls_r;
    cls_t        cls_s;
    logic [15:0] wait_cnt;
    logic [31:0] next_pc_s;
    logic        misalign_s;
    logic        rd_nz_s;
    logic [10:0] key_s;

    function automatic cls_t classify(input logic [10:0] key);
        logic       b30;
        logic [2:0] f3;
        logic [6:0] op;
        cls_t       c;
        b30 = key[10];
        f3  = key[9:7];
        op  = key[6:0];
        case (op)
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            7'b1101111: c = C_JAL;
            7'b1100111: c = (f3 == 3'b000) ? C_JALR : C_ILLEGAL;
            7'b1100011: c = (f3 == 3'b010 || f3 == 3'b011) ? C_ILLEGAL : C_BRANCH;
            7'b0000011: c = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ? C_ILLEGAL : C_LOAD;
            7'b0100011: c = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ? C_STORE : C_ILLEGAL;
            // SLLI never has bit 30 set; SRLI/SRAI use it to pick the shift kind
            7'b0010011: c = (f3 == 3'b001 && b30) ? C_ILLEGAL : C_OPIMM;
            7'b0110011: c = (b30 && f3 != 3'b000 && f3 != 3'b101) ? C_ILLEGAL : C_OP;
            default:    c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic writes_rd(input cls_t c);
        logic w;
        case (c)
            C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    assign imem_addr = pc;
    assign key_s     = {instr[30], instr[14:12], instr[6:0]};
    assign rd_nz_s   = (instr[11:7] != 5'd0);

    // Instruction classification from the latched IR.
    always_comb begin
        cls_s = classify(key_s);
    end

    // Next-pc selection used during WB.
    always_comb begin
        next_pc_s = pc + 32'd4;
        case (cls_r)
            C_JAL:    next_pc_s = branch_target;
            C_JALR:   next_pc_s = jalr_target;
            C_BRANCH: begin
                if (branch_taken) begin
                    next_pc_s = branch_target;
                end else begin
                    next_pc_s = pc + 32'd4;
                end
            end
            default:  next_pc_s = pc + 32'd4;
        endcase
        misalign_s = (next_pc_s[1:0] != 2'b00);
    end

`ifdef RV_ILLEGAL_TRAP_EN
    logic illegal_r;
    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    // Control state machine with registered request/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            cls_r    <= C_ILLEGAL;
            pc       <= RESET_PC;
            instr    <= 32'h0000_0000;
            wait_cnt <= 16'd0;
            fault    <= 1'b0;
            reg_we   <= 1'b0;
            wb_sel   <= 2'd0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            imem_req <= 1'b1;
`ifdef RV_ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            reg_we <= 1'b0;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DECODE: begin
                    cls_r <= cls_s;
`ifdef RV_ILLEGAL_TRAP_EN
                    if (cls_s == C_ILLEGAL) begin
                        fault     <= 1'b1;
                        illegal_r <= 1'b1;
                        state     <= FAULT;
                    end else begin
                        state <= EXECUTE;
                    end
`else
                    state <= EXECUTE;
`endif
                end
                EXECUTE: begin
                    if (cls_r == C_LOAD || cls_r == C_STORE) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls_r == C_STORE);
                        wait_cnt <= 16'd0;
                        state    <= MEM;
                    end else begin
                        reg_we <= writes_rd(cls_r) && rd_nz_s;
                        wb_sel <= (cls_r == C_JAL || cls_r == C_JALR) ? 2'd2 : 2'd0;
                        state  <= WB;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        reg_we   <= (cls_r == C_LOAD) && rd_nz_s;
                        wb_sel   <= (cls_r == C_LOAD) ? 2'd1 : 2'd0;
                        state    <= WB;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WB: begin
                    // A misaligned target faults and leaves pc pointing at the offending instruction
                    if (misalign_s) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        pc       <= next_pc_s;
                        imem_req <= 1'b1;
                        wait_cnt <= 16'd0;
                        state    <= FETCH;
                    end
                end
                FAULT: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    fault    <= 1'b1;
                    state    <= FAULT;
                end
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    fault    <= 1'b1;
                    state    <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_control_fsm.sv
// Scoreboard bench for rv_control_fsm: expected per-instruction results are queued at issue and popped when
// the instruction retires. Honours RV_ILLEGAL_TRAP_EN for the illegal-instruction scenario.
module tb_rv_control_fsm;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] instr;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] pc;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        fault;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    // cycles: cycles from FETCH to next FETCH (or to fault); we_cyc: cycle index of reg_we (0 = none)
    typedef struct packed {
        logic [7:0]  cycles;
        logic [7:0]  we_cyc;
        logic [1:0]  sel;
        logic [7:0]  dreq;
        logic        dwe;
        logic [31:0] pc;
    } obs_t;

    obs_t exp_q[$];

    rv_control_fsm #(
        .RESET_PC   (32'h0000_0000),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .instr        (instr),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jalr_target  (jalr_target),
        .pc           (pc),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .fault        (fault),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs one instruction from the start of a FETCH cycle and measures what the DUT does.
    task automatic exec_instr(input logic [31:0] ir, input int dwait, output obs_t o);
        int cyc, wec, dreq;
        logic [1:0] sel;
        logic dwe;
        cyc = 0; wec = 0; dreq = 0; sel = 2'd0; dwe = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (fault || (imem_req && cyc > 0)) break;
            cyc++;
            if (reg_we) begin
                wec = cyc;
                sel = wb_sel;
            end
            if (dmem_req) begin
                dreq++;
                dwe = dwe | dmem_we;
            end
            imem_ack   = imem_req;
            imem_rdata = ir;
            dmem_ack   = dmem_req && (dreq > dwait);
            tick();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        o = obs_t'{8'(cyc), 8'(wec), sel, 8'(dreq), dwe, pc};
    endtask

    task automatic retire(input string name, input logic [31:0] ir, input int dwait);
        obs_t o, e;
        exec_instr(ir, dwait, o);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            $display("FAIL %s: got cyc=%0d we_cyc=%0d sel=%0d dreq=%0d dwe=%0b pc=%h, expected cyc=%0d we_cyc=%0d sel=%0d dreq=%0d dwe=%0b pc=%h",
                     name, o.cycles, o.we_cyc, o.sel, o.dreq, o.dwe, o.pc, e.cycles, e.we_cyc, e.sel, e.dreq, e.dwe, e.pc);
        end else begin
            passes++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, instr} !== 64'h0) begin
            $display("FAIL reset_pc_ir: got pc=%h instr=%h, expected 0/0", pc, instr);
        end else begin
            passes++;
        end
        checks++;
        if ({fault, illegal, reg_we, dmem_req, imem_req} !== 5'b00001) begin
            $display("FAIL reset_flags: got f/il/we/dreq/ireq=%b, expected 00001", {fault, illegal, reg_we, dmem_req, imem_req});
        end else begin
            passes++;
        end
    endtask

    task automatic test_program();
        // ADDI x1,x0,5 ; LW x2 (3 wait) ; BEQ taken ; SW ; JAL x1 ; ADDI x0 ; JALR x1
        branch_taken = 1'b1; branch_target = 32'h20; jalr_target = 32'h0;
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd0, 8'd0, 1'b0, 32'h4});
        retire("addi", 32'h00500093, 0);
        exp_q.push_back(obs_t'{8'd8, 8'd8, 2'd1, 8'd4, 1'b0, 32'h8});
        retire("lw_wait3", 32'h00002103, 3);
        exp_q.push_back(obs_t'{8'd4, 8'd0, 2'd0, 8'd0, 1'b0, 32'h20});
        retire("beq_taken", 32'h00000C63, 0);
        exp_q.push_back(obs_t'{8'd5, 8'd0, 2'd0, 8'd1, 1'b1, 32'h24});
        retire("sw_zero_wait", 32'h00102023, 0);
        branch_target = 32'h2C;
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd2, 8'd0, 1'b0, 32'h2C});
        retire("jal", 32'h008000EF, 0);
        exp_q.push_back(obs_t'{8'd4, 8'd0, 2'd0, 8'd0, 1'b0, 32'h30});
        retire("addi_rd0", 32'h00500013, 0);
        jalr_target = 32'h100;
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd2, 8'd0, 1'b0, 32'h100});
        retire("jalr", 32'h000000E7, 0);
    endtask

    task automatic test_misaligned();
        branch_taken = 1'b1; branch_target = 32'h102;
        exp_q.push_back(obs_t'{8'd4, 8'd0, 2'd0, 8'd0, 1'b0, 32'h100});
        retire("misaligned_branch", 32'h00000C63, 0);
        checks++;
        if ({fault, imem_req} !== 2'b10) begin
            $display("FAIL misaligned_fault: got fault/imem_req=%b, expected 10", {fault, imem_req});
        end else begin
            passes++;
        end
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        branch_taken = 1'b0; branch_target = 32'h20;
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd0, 8'd0, 1'b0, 32'h4});
        retire("addi_a", 32'h00500093, 0);
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd0, 8'd0, 1'b0, 32'h8});
        retire("addi_b", 32'h00500093, 0);
        exp_q.push_back(obs_t'{8'd4, 8'd0, 2'd0, 8'd0, 1'b0, 32'hC});
        retire("beq_not_taken", 32'h00000C63, 0);
    endtask

    task automatic test_timeout();
        int reqc;
        int exp_reqc;
        do_reset();
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd0, 8'd0, 1'b0, 32'h4});
        retire("addi_pre_timeout", 32'h00500093, 0);
        exp_reqc = 4;
        reqc = 0;
        imem_ack = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (fault) break;
            if (imem_req) reqc++;
            tick();
        end
        checks++;
        if (reqc !== exp_reqc) begin
            $display("FAIL timeout_cycles: got %0d request cycles, expected %0d", reqc, exp_reqc);
        end else begin
            passes++;
        end
        checks++;
        if ({fault, imem_req, pc} !== {1'b1, 1'b0, 32'h4}) begin
            $display("FAIL timeout_state: got fault=%b imem_req=%b pc=%h, expected 1 0 00000004", fault, imem_req, pc);
        end else begin
            passes++;
        end
        do_reset();
        checks++;
        if ({fault, imem_req, pc} !== {1'b0, 1'b1, 32'h0}) begin
            $display("FAIL timeout_reset: got fault=%b imem_req=%b pc=%h, expected 0 1 00000000", fault, imem_req, pc);
        end else begin
            passes++;
        end
    endtask

    task automatic test_illegal();
        do_reset();
`ifdef RV_ILLEGAL_TRAP_EN
        exp_q.push_back(obs_t'{8'd2, 8'd0, 2'd0, 8'd0, 1'b0, 32'h0});
        retire("illegal_trap", 32'hFFFFFFFF, 0);
        checks++;
        if ({fault, illegal} !== 2'b11) begin
            $display("FAIL illegal_flags: got fault/illegal=%b, expected 11", {fault, illegal});
        end else begin
            passes++;
        end
`else
        exp_q.push_back(obs_t'{8'd4, 8'd0, 2'd0, 8'd0, 1'b0, 32'h4});
        retire("illegal_nop", 32'hFFFFFFFF, 0);
        checks++;
        if ({fault, illegal} !== 2'b00) begin
            $display("FAIL illegal_flags: got fault/illegal=%b, expected 00", {fault, illegal});
        end else begin
            passes++;
        end
`endif
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd0, 8'd0, 1'b0, 32'h4});
        retire("addi_pre_sw", 32'h00500093, 0);
        imem_rdata = 32'h00102023;
        imem_ack   = 1'b1;
        dmem_ack   = 1'b0;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({dmem_req, dmem_we} !== 2'b11) begin
            $display("FAIL sw_in_mem: got dmem_req/we=%b, expected 11", {dmem_req, dmem_we});
        end else begin
            passes++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({dmem_req, pc} !== {1'b0, 32'h0}) begin
            $display("FAIL mid_mem_reset: got dmem_req=%b pc=%h, expected 0 00000000", dmem_req, pc);
        end else begin
            passes++;
        end
        rst = 1'b0;
        checks++;
        if ({imem_req, fault} !== 2'b10) begin
            $display("FAIL after_release: got imem_req/fault=%b, expected 10", {imem_req, fault});
        end else begin
            passes++;
        end
        exp_q.push_back(obs_t'{8'd4, 8'd4, 2'd0, 8'd0, 1'b0, 32'h4});
        retire("addi_after_abort", 32'h00500093, 0);
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        dmem_ack      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jalr_target   = 32'h0;
        test_reset();
        test_program();
        test_misaligned();
        test_branch_not_taken();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rv_control_fsm.md
RV_CONTROL_FSM -- requirements
Module: rv_control_fsm

Interface
REQ-001 The parameter RESET_PC SHALL default to 32'h0000_0000 and SHALL be the PC value loaded on reset.
REQ-002 The parameter MEM_TIMEOUT SHALL default to 255 and SHALL be the maximum number of request cycles without ack before a fault is raised.
REQ-003 The ports SHALL be as follows; clock and reset are listed first, and width is in bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  equals pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- instr  out  32  latched instruction register (IR).
- branch_taken  in  1  comparator result from the datapath for the current IR.
- branch_target  in  32  pc + B/J immediate.
- jalr_target  in  32  (rs1 + I immediate) & ~1.
- pc  out  32  current program counter.
- reg_we  out  1  register-file write strobe.
- wb_sel  out  2  write-back source: 0 = ALU, 1 = load data, 2 = pc+4.
- fault  out  1  sticky fault indication.
- illegal  out  1  sticky flag; set when the fault cause is an illegal instruction.

Function
REQ-004 The FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WB and FAULT.
REQ-005 FETCH SHALL assert imem_req; on imem_ack the IR SHALL load imem_rdata and the FSM SHALL go to DECODE; without ack it SHALL stay in FETCH.
REQ-006 DECODE SHALL last 1 cycle and SHALL classify the IR using the key {instr[30], instr[14:12], instr[6:0]}.
- The accepted classes are the RV32I base set: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM and OP.
REQ-007 EXECUTE SHALL last 1 cycle; loads (opcode 0000011) and stores (opcode 0100011) SHALL then go to MEM, and all other instructions SHALL go to WB.
REQ-008 MEM SHALL hold dmem_req high, with dmem_we = 1 for stores, until dmem_ack is sampled high, then SHALL go to WB.
REQ-009 WB SHALL last 1 cycle, SHALL update pc and SHALL return to FETCH.
- pc update:
  - JAL → branch_target.
  - JALR → jalr_target.
  - branch with branch_taken = 1 → branch_target.
  - all other cases → pc + 4 (modulo 2^32).
REQ-010 reg_we SHALL pulse for exactly the WB cycle for LUI, AUIPC, JAL, JALR, loads, OP-IMM and OP, and SHALL be 0 for branches and stores.
- It SHALL be 0 when instr[11:7] = 0.
REQ-011 wb_sel SHALL be 1 for loads, 2 for JAL/JALR and 0 otherwise; it is only meaningful while reg_we = 1.
REQ-012 imem_ack SHALL be ignored outside FETCH, and dmem_ack SHALL be ignored outside MEM.
REQ-013 An ack sampled in the first request cycle SHALL complete the access, giving zero wait states.
REQ-014 Cycles per instruction with zero-wait memory SHALL be 4 for non-memory instructions and 5 for loads and stores.
REQ-015 A 16-bit wait counter SHALL clear on entry to FETCH or MEM and SHALL increment each cycle the request is held without ack.
- When the counter reaches MEM_TIMEOUT, the FSM SHALL enter FAULT.
REQ-016 FAULT SHALL drive all requests and strobes to 0, hold fault = 1 and hold pc; it SHALL exit only through rst.
REQ-017 A misaligned pc update (target[1:0] ≠ 0) SHALL enter FAULT instead of FETCH, and pc SHALL keep its old value.

Reset
REQ-018 While rst is high at a clock edge, the FSM SHALL go to FETCH with the following values:
- pc = RESET_PC, instr = 0, wait counter = 0.
- fault = 0, illegal = 0, reg_we = 0, dmem_req = 0.
REQ-019 In the first cycle after rst deasserts, imem_req SHALL be 1.
REQ-020 Reset asserted in any state, including mid-MEM with dmem_req high, SHALL abort the access; dmem_req SHALL be 0 on the next cycle.

Configuration
REQ-021 When RV_ILLEGAL_TRAP_EN is defined, an unrecognised key or opcode in DECODE SHALL enter FAULT with illegal = 1.
REQ-022 When RV_ILLEGAL_TRAP_EN is not defined, an illegal instruction SHALL execute as a NOP: DECODE→EXECUTE→WB, pc + 4, reg_we = 0; illegal SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset release, then ADDI x1,x0,5 (32'h00500093) with zero-wait ack → imem_req in cycle 1, reg_we in cycle 4 with wb_sel = 0, pc = 4 in cycle 5.
- LW x2,0(x0) (32'h00002103) with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles with dmem_we = 0, reg_we with wb_sel = 1, 8 cycles total.
- BEQ at pc = 8 with branch_taken = 1 and branch_target = 32'h20 → reg_we stays 0, pc = 32'h20; with branch_taken = 0 → pc = 32'hC.
- imem_ack held low with MEM_TIMEOUT = 4 → fault = 1 after 4 request cycles, imem_req = 0, pc unchanged; rst clears fault.
- Instruction 32'hFFFFFFFF → with RV_ILLEGAL_TRAP_EN: fault = 1 and illegal = 1; without it: pc + 4 and no reg_we.
- rst asserted during MEM of SW → dmem_req = 0 next cycle, pc = RESET_PC, imem_req = 1 after release.
